// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, decoder FSM states and letter-index width.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam int         LETTER_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } ps2_state_e;

endpackage

// File: rtl/scan_to_letter.sv
// Combinational set-2 scan code to letter index (A=0 .. Z=25) with a hit flag.
module scan_to_letter
    import ps2_pkg::*;
(
    input  logic [7:0]          i_code,
    output logic [LETTER_W-1:0] o_index,
    output logic                o_hit
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_index = '0;
        o_hit   = 1'b1;
        case (i_code)
            8'h1C: o_index = 5'd0;
            8'h32: o_index = 5'd1;
            8'h21: o_index = 5'd2;
            8'h23: o_index = 5'd3;
            8'h24: o_index = 5'd4;
            8'h2B: o_index = 5'd5;
            8'h34: o_index = 5'd6;
            8'h33: o_index = 5'd7;
            8'h43: o_index = 5'd8;
            8'h3B: o_index = 5'd9;
            8'h42: o_index = 5'd10;
            8'h4B: o_index = 5'd11;
            8'h3A: o_index = 5'd12;
            8'h31: o_index = 5'd13;
            8'h44: o_index = 5'd14;
            8'h4D: o_index = 5'd15;
            8'h15: o_index = 5'd16;
            8'h2D: o_index = 5'd17;
            8'h1B: o_index = 5'd18;
            8'h2C: o_index = 5'd19;
            8'h3C: o_index = 5'd20;
            8'h2A: o_index = 5'd21;
            8'h1D: o_index = 5'd22;
            8'h22: o_index = 5'd23;
            8'h35: o_index = 5'd24;
            8'h1A: o_index = 5'd25;
            default: o_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_letter_decoder.sv
// Decodes PS/2 make/break/extended byte sequences into a one-cycle letter press pulse.
// Define REPEAT_FILTER_EN to suppress typematic repeats of the currently held key.
module ps2_letter_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                pressed,
    output logic [LETTER_W-1:0] letter,
    output logic                key_held
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_held_code;
    logic                r_pressed;
    logic [LETTER_W-1:0] r_letter;
    logic                r_key_held;

    logic [LETTER_W-1:0] w_index;
    logic                w_hit;
    logic                w_suppress;

    scan_to_letter u_scan_to_letter (
        .i_code  (byte_data),
        .o_index (w_index),
        .o_hit   (w_hit)
    );

`ifdef REPEAT_FILTER_EN
    assign w_suppress = r_key_held && (byte_data == r_held_code);
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_held_code <= 8'h00;
            r_pressed   <= 1'b0;
            r_letter    <= '0;
            r_key_held  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the pulse defaults low and is set only on a make.
            r_pressed <= 1'b0;
            if (byte_valid) begin
                r_cnt <= '0;
                unique case (r_state)
                    IDLE: begin
                        if (byte_data == PS2_EXT) begin
                            r_state <= EXT;
                        end else if (byte_data == PS2_BREAK) begin
                            r_state <= BRK;
                        end else if (w_hit) begin
                            if (!w_suppress) begin
                                r_pressed <= 1'b1;
                                r_letter  <= w_index;
                            end
                            r_key_held  <= 1'b1;
                            r_held_code <= byte_data;
                        end
                    end
                    BRK: begin
                        if (byte_data == r_held_code) begin
                            r_key_held  <= 1'b0;
                            r_held_code <= 8'h00;
                        end
                        r_state <= IDLE;
                    end
                    EXT:     r_state <= (byte_data == PS2_BREAK) ? EXT_BRK : IDLE;
                    EXT_BRK: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                // A prefix with no follow-up byte is abandoned silently.
                if (r_cnt == CNT_LAST) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign pressed  = r_pressed;
    assign letter   = r_letter;
    assign key_held = r_key_held;

endmodule
